// File: rtl/k12a_mem_controller.sv
// k12a_mem_controller: single-byte bus initiator for the k12a ROM (28256) /
// SRAM (62256) pair. Decodes addr[15] into the two chip enables and runs an
// IDLE -> SETUP -> STROBE -> HOLD sequence with parameterised wait states.
// Every memory-side control and bus enable comes straight from a flop.
// Optional feature macro: K12A_MEMCTL_ROM_FAULT_EN adds rsp_fault, which
// flags a completed write aimed at ROM.
module k12a_mem_controller #(
    parameter int unsigned SETUP_CYCLES  = 1,  // 1..15
    parameter int unsigned STROBE_CYCLES = 2,  // 1..15
    parameter int unsigned HOLD_CYCLES   = 1   // 1..15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
`ifdef K12A_MEMCTL_ROM_FAULT_EN
    output logic        rsp_fault,
`endif
    output logic        mem_rom_ce_n,
    output logic        mem_ram_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    inout  wire  [15:0] addr_bus,
    inout  wire  [7:0]  data_bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    // Down-counter reload values: a phase of N cycles counts N-1 .. 0.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Latched request, stable for the whole access.
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        ram_sel_q, ram_sel_d;

    // Registered memory-side controls and bus enables.
    logic        rom_ce_n_q, rom_ce_n_d;
    logic        ram_ce_n_q, ram_ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        addr_oe_q, addr_oe_d;
    logic        data_oe_q, data_oe_d;

    // Core-side response.
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    logic        busy_d;

    // Next-state, request latch, read capture and the registered controls
    // derived from where the sequencer will be after this edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; otherwise synthesis would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        ram_sel_d   = ram_sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    write_d   = req_write;
                    ram_sel_d = req_addr[15];
                    state_d   = ST_SETUP;
                    cnt_d     = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    // The memory has had the full strobe window to drive
                    // the bus; sample it at the edge that closes OE_n.
                    if (!write_q) begin
                        rsp_rdata_d = data_bus;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Controls are computed from the next state so that, once
        // registered, they line up exactly with the phase they belong to.
        // A ROM write keeps all strobes and CEs idle but still runs the
        // full timing with the address on the bus.
        busy_d     = (state_d != ST_IDLE);
        addr_oe_d  = busy_d;
        rom_ce_n_d = !(busy_d && !ram_sel_d && !write_d);
        ram_ce_n_d = !(busy_d && ram_sel_d);
        data_oe_d  = busy_d && ram_sel_d && write_d;
        oe_n_d     = !((state_d == ST_STROBE) && !write_d);
        we_n_d     = !((state_d == ST_STROBE) && write_d && ram_sel_d);
    end

    // State, counter, request latch and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            write_q     <= 1'b0;
            ram_sel_q   <= 1'b0;
            rom_ce_n_q  <= 1'b1;
            ram_ce_n_q  <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            addr_oe_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            ram_sel_q   <= ram_sel_d;
            rom_ce_n_q  <= rom_ce_n_d;
            ram_ce_n_q  <= ram_ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            addr_oe_q   <= addr_oe_d;
            data_oe_q   <= data_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef K12A_MEMCTL_ROM_FAULT_EN
    logic rsp_fault_q;

    // Flag a ROM write on the same cycle as its completion pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_fault_q <= rsp_valid_d && write_q && !ram_sel_q;
        end
    end

    assign rsp_fault = rsp_fault_q;
`endif

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mem_rom_ce_n = rom_ce_n_q;
    assign mem_ram_ce_n = ram_ce_n_q;
    assign mem_oe_n     = oe_n_q;
    assign mem_we_n     = we_n_q;
    assign addr_bus     = addr_oe_q ? addr_q  : 16'hzzzz;
    assign data_bus     = data_oe_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_k12a_mem_controller.sv
// Directed bench for k12a_mem_controller: a default-timing instance backed by
// a behavioural ROM/RAM model, plus a SETUP=2/STROBE=3/HOLD=2 instance used
// for the ROM-write timing case.
module tb_k12a_mem_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_valid2;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;

    logic        req_ready, rsp_valid, mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n;
    logic [7:0]  rsp_rdata;
    wire  [15:0] addr_bus;
    wire  [7:0]  data_bus;

    logic        req_ready2, rsp_valid2, rom_ce_n2, ram_ce_n2, oe_n2, we_n2;
    logic [7:0]  rsp_rdata2;
    wire  [15:0] addr_bus2;
    wire  [7:0]  data_bus2;
`ifdef K12A_MEMCTL_ROM_FAULT_EN
    logic        rsp_fault, rsp_fault2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    k12a_mem_controller dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef K12A_MEMCTL_ROM_FAULT_EN
        .rsp_fault(rsp_fault),
`endif
        .mem_rom_ce_n(mem_rom_ce_n), .mem_ram_ce_n(mem_ram_ce_n),
        .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .addr_bus(addr_bus), .data_bus(data_bus)
    );

    k12a_mem_controller #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
`ifdef K12A_MEMCTL_ROM_FAULT_EN
        .rsp_fault(rsp_fault2),
`endif
        .mem_rom_ce_n(rom_ce_n2), .mem_ram_ce_n(ram_ce_n2),
        .mem_oe_n(oe_n2), .mem_we_n(we_n2),
        .addr_bus(addr_bus2), .data_bus(data_bus2)
    );

    // Behavioural memories: drive data_bus while a chip is enabled with OE_n
    // low; the RAM latches the bus on every clock edge seen with WE_n low.
    logic [7:0] rom_mem [0:32767];
    logic [7:0] ram_mem [0:32767];
    logic       model_drive;
    logic [7:0] model_data;

    assign model_drive = !mem_oe_n && (!mem_rom_ce_n || !mem_ram_ce_n);
    assign model_data  = !mem_rom_ce_n ? rom_mem[addr_bus[14:0]] : ram_mem[addr_bus[14:0]];
    assign data_bus    = model_drive ? model_data : 8'hzz;

    always @(posedge clock) begin
        if (!mem_ram_ce_n && !mem_we_n) ram_mem[addr_bus[14:0]] <= data_bus;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic rom, input logic ram,
                              input logic oe, input logic we, input logic vld);
        check({tag, "_rom_ce_n"}, 16'(mem_rom_ce_n), 16'(rom));
        check({tag, "_ram_ce_n"}, 16'(mem_ram_ce_n), 16'(ram));
        check({tag, "_oe_n"},     16'(mem_oe_n),     16'(oe));
        check({tag, "_we_n"},     16'(mem_we_n),     16'(we));
        check({tag, "_rsp_valid"}, 16'(rsp_valid),   16'(vld));
    endtask

    initial begin
        int rsp_at [2];
        int n_rsp;
        int overlap;
        int bad;
        int done_at;

        rom_mem[15'h0123] = 8'h3C;
        ram_mem[15'h0010] = 8'h00;
        ram_mem[15'h0011] = 8'h00;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_valid2 = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;

        // Reset held for two edges.
        tick();
        tick();
        expect_ctl("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_addr_z", 16'(addr_bus === 16'hzzzz), 16'd1);
        check("reset_data_z", 16'(data_bus === 8'hzz), 16'd1);
        check("reset_ready", 16'(req_ready), 16'd1);
        check("reset_rdata", 16'(rsp_rdata), 16'h0000);
        reset_n = 1'b1;
        tick();

        // RAM write 0x8010 <= A5 with default timing.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h8010; req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0;
        expect_ctl("wr_setup", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("wr_setup_addr", addr_bus, 16'h8010);
        check("wr_setup_data", 16'(data_bus), 16'h00A5);
        check("wr_setup_ready", 16'(req_ready), 16'd0);
        tick();
        expect_ctl("wr_strobe1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wr_strobe1_data", 16'(data_bus), 16'h00A5);
        tick();
        expect_ctl("wr_strobe2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_ctl("wr_hold", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("wr_hold_data", 16'(data_bus), 16'h00A5);
        check("wr_hold_addr", addr_bus, 16'h8010);
        tick();
        expect_ctl("wr_done", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("wr_done_addr_z", 16'(addr_bus === 16'hzzzz), 16'd1);
        check("wr_done_data_z", 16'(data_bus === 8'hzz), 16'd1);
        check("wr_done_ready", 16'(req_ready), 16'd1);
        check("wr_model_ram", 16'(ram_mem[15'h0010]), 16'h00A5);
        tick();
        check("wr_pulse_end", 16'(rsp_valid), 16'd0);

        // ROM read 0x0123, model byte 3C.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0123;
        tick();
        req_valid = 1'b0;
        expect_ctl("rd_setup", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rd_setup_data_z", 16'(data_bus === 8'hzz), 16'd1);
        tick();
        expect_ctl("rd_strobe1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_ctl("rd_strobe2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rd_strobe2_data", 16'(data_bus), 16'h003C);
        tick();
        expect_ctl("rd_hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rd_hold_data_z", 16'(data_bus === 8'hzz), 16'd1);
        tick();
        expect_ctl("rd_done", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rd_rdata", 16'(rsp_rdata), 16'h003C);
        tick();

        // Back-to-back: read 0x8010, then write 0x8011 <= 5A, req_valid held.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h8010;
        tick();
        req_write = 1'b1; req_addr = 16'h8011; req_wdata = 8'h5A;
        rsp_at[0] = -1; rsp_at[1] = -1; n_rsp = 0; overlap = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (!mem_oe_n && !mem_we_n) overlap++;
            if (rsp_valid && n_rsp < 2) begin
                rsp_at[n_rsp] = cyc;
                if (n_rsp == 0) begin
                    check("b2b_rd_rdata", 16'(rsp_rdata), 16'h00A5);
                    check("b2b_ready_in_rsp", 16'(req_ready), 16'd1);
                end
                n_rsp++;
            end
            if (cyc == 5) req_valid = 1'b0;
        end
        check("b2b_first_rsp", 16'(rsp_at[0]), 16'd4);
        check("b2b_second_rsp", 16'(rsp_at[1]), 16'd9);
        check("b2b_oe_we_overlap", 16'(overlap), 16'd0);
        check("b2b_model_ram", 16'(ram_mem[15'h0011]), 16'h005A);
        check("b2b_rdata_held", 16'(rsp_rdata), 16'h00A5);

        // Reset during STROBE of a RAM write.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h8020; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_mid_we_low", 16'(mem_we_n), 16'd0);
        reset_n = 1'b0;
        tick();
        expect_ctl("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_mid_addr_z", 16'(addr_bus === 16'hzzzz), 16'd1);
        check("rst_mid_data_z", 16'(data_bus === 8'hzz), 16'd1);
        reset_n = 1'b1;
        bad = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (rsp_valid) bad++;
        end
        check("rst_mid_no_rsp", 16'(bad), 16'd0);
        check("rst_mid_ready", 16'(req_ready), 16'd1);

        // ROM write on the 2/3/2 instance: no CE/WE, data Z, done after 7 edges.
        req_valid2 = 1'b1; req_write = 1'b1; req_addr = 16'h0005; req_wdata = 8'h99;
        tick();
        req_valid2 = 1'b0;
        bad = 0; done_at = -1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc > 1) tick();
            if (!rom_ce_n2 || !ram_ce_n2 || !we_n2 || !(data_bus2 === 8'hzz)) bad++;
            if (rsp_valid2 && done_at < 0) begin
                done_at = cyc - 1;
`ifdef K12A_MEMCTL_ROM_FAULT_EN
                check("romwr_fault_pulse", 16'(rsp_fault2), 16'd1);
`endif
            end
            if (cyc == 4) check("romwr_addr_driven", addr_bus2, 16'h0005);
        end
        check("romwr_no_strobe", 16'(bad), 16'd0);
        check("romwr_latency", 16'(done_at), 16'd7);
        check("romwr_addr_released", 16'(addr_bus2 === 16'hzzzz), 16'd1);
`ifdef K12A_MEMCTL_ROM_FAULT_EN
        check("romwr_fault_cleared", 16'(rsp_fault2), 16'd0);
        check("romwr_fault_default_inst", 16'(rsp_fault), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/k12a_mem_controller.md
Name: k12a_mem_controller

Overview:
Bus initiator for the k12a memory subsystem: accepts single-byte read/write requests from the core and sequences the asynchronous ROM (28256) / SRAM (62256) strobes on the shared addr_bus/data_bus. It decodes addr[15] into rom/ram chip enables and runs a setup/strobe/hold sequence with parameterised wait states. All memory-side control outputs are registered, so they are glitch-free.

Parameters:
SETUP_CYCLES, 1, cycles the address/CE are stable before the OE/WE strobe; legal range 1..15
STROBE_CYCLES, 2, cycles OE_n or WE_n is held low; legal range 1..15
HOLD_CYCLES, 1, cycles the address/data/CE are held after the strobe deasserts; legal range 1..15

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
req_valid  input  1  core requests an access
req_ready  output  1  controller idle and able to accept; high only in IDLE
req_write  input  1  1 = write, 0 = read
req_addr  input  16  byte address; bit 15 = 0 selects ROM, bit 15 = 1 selects RAM
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  8  read data; valid with rsp_valid on reads and held until the next read completes
mem_rom_ce_n  output  1  ROM chip enable, active low
mem_ram_ce_n  output  1  RAM chip enable, active low
mem_oe_n  output  1  output enable, active low
mem_we_n  output  1  write enable, active low
addr_bus  inout  16  driven during an access, high-Z otherwise
data_bus  inout  8  driven only during a RAM write access, high-Z otherwise

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous, active-low, on reset_n.
- Reset values: state=IDLE, mem_rom_ce_n=1, mem_ram_ce_n=1, mem_oe_n=1, mem_we_n=1, addr_bus=Z, data_bus=Z, rsp_valid=0, rsp_rdata=8'h00.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. A 4-bit down-counter is loaded with N-1 on entry to each timed state. The state advances when the counter reaches 0.
- Accept: at an edge where state=IDLE and req_valid=1. The controller latches the request, enters SETUP, and drives addr_bus=req_addr and the selected CE_n=0. The other CE_n stays 1.
- SETUP: lasts SETUP_CYCLES. On writes to RAM, data_bus is also driven from SETUP onwards.
- STROBE: lasts STROBE_CYCLES.
  - Read: mem_oe_n=0.
  - RAM write: mem_we_n=0, mem_oe_n=1.
  - rsp_rdata is captured from data_bus at the edge that ends the final STROBE cycle.
- HOLD: lasts HOLD_CYCLES. OE_n and WE_n are back to 1; addr, data and CE are still driven.
- Completion: at the edge ending HOLD, the controller returns to IDLE, sets rsp_valid=1 for exactly one cycle, sets CE_n=1, and releases both buses.
- Latency: request acceptance to rsp_valid is 1+SETUP+STROBE+HOLD-1 edges; the default is 4.
- Back-to-back: a new request may be accepted in the cycle rsp_valid=1, giving a throughput of one access per 1+S+T+H cycles (5 by default).
- Invariants:
  - OE_n and WE_n are never both 0.
  - data_bus is never driven while OE_n=0.
  - CE_n, OE_n and WE_n change only on clock edges.
- ROM write (req_write=1, addr[15]=0): the full sequence timing runs, but no CE or WE is asserted and data_bus stays Z. The access completes with rsp_valid as normal.
- Reset mid-operation: at the reset edge, all strobes and CEs are deasserted, the buses are released, and no rsp_valid is produced for the aborted access.
- req_* inputs are ignored outside IDLE.

Optional Feature:
K12A_MEMCTL_ROM_FAULT_EN
- Defined: adds an output port rsp_fault (1 bit). It pulses with rsp_valid on a ROM write and is 0 otherwise. Its reset value is 0.
- Undefined: the port is absent and ROM writes complete silently as above.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> all CE/OE/WE=1, both buses Z, req_ready=1, rsp_valid=0.
- RAM write with defaults: addr=16'h8010, wdata=8'hA5 -> mem_ram_ce_n=0 for 4 cycles, mem_we_n=0 for exactly 2 cycles in the middle, data_bus=A5 throughout, rsp_valid after 4 edges; a model RAM holds A5 at 0x0010.
- ROM read: addr=16'h0123, model ROM byte=8'h3C -> mem_rom_ce_n=0, mem_oe_n=0 for 2 cycles, data_bus never driven by the DUT, rsp_rdata=3C with rsp_valid.
- Back-to-back: read 16'h8010 then write 16'h8011 with req_valid held high -> second acceptance in the rsp_valid cycle, accesses 5 cycles apart, no cycle with OE_n=0 and WE_n=0 together.
- Reset mid-access: assert reset_n=0 during STROBE of a RAM write -> next edge has WE_n=1, CE_n=1, buses Z, and no rsp_valid.
- With SETUP=2, STROBE=3, HOLD=2 and the macro defined: write 16'h0005 -> no CE asserted, rsp_valid and rsp_fault pulse after 7 edges.
